// File: rtl/mac_rx_ifc_if.sv
// Bundle between the RMII receive deserializer, the receive interface block and the packet consumer.
// The receiver uses the slave modport; the stream/consumer side uses the master modport.
interface mac_rx_ifc_if #(
   parameter int MAX_BYTES  = 1518,
   parameter int DROP_CTR_W = 8
);
   logic                       rx_axi_valid_i;
   logic [1:0]                 rx_axi_data_i;
   logic                       release_i;
   logic [MAX_BYTES-1:0][7:0]  pktbuf_o;
   logic [10:0]                pktbuf_maxaddr_o;
   logic                       doorbell_o;
   logic                       pkt_held_o;
   logic [DROP_CTR_W-1:0]      drop_count_o;

   modport slave (
      input  rx_axi_valid_i,
      input  rx_axi_data_i,
      input  release_i,
      output pktbuf_o,
      output pktbuf_maxaddr_o,
      output doorbell_o,
      output pkt_held_o,
      output drop_count_o
   );

   modport master (
      output rx_axi_valid_i,
      output rx_axi_data_i,
      output release_i,
      input  pktbuf_o,
      input  pktbuf_maxaddr_o,
      input  doorbell_o,
      input  pkt_held_o,
      input  drop_count_o
   );
endinterface

// File: rtl/mac_rx_ifc.sv
// Assembles LSB-first dibits into a flat packet buffer, rings a doorbell at frame end and
// holds the frame until the consumer releases it; bad or unwanted frames bump a saturating counter.
module mac_rx_ifc #(
   parameter int MAX_BYTES  = 1518,
   parameter int DROP_CTR_W = 8
) (
   input logic          clk,
   input logic          rst,
   mac_rx_ifc_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RX,
      ST_DROP,
      ST_HOLD
   } state_t;

   localparam logic [10:0] FULL_ADDR = 11'(MAX_BYTES);

   state_t                     state_q, state_d;
   logic [MAX_BYTES-1:0][7:0]  pktbuf_q;
   logic [10:0]                byteAddr_q, byteAddr_d;
   logic [10:0]                maxAddr_q, maxAddr_d;
   logic [1:0]                 dibitCtr_q, dibitCtr_d;
   logic [5:0]                 shift_q, shift_d;
   logic                       valid_q;
   logic                       armed_q;
   logic                       doorbell_q, doorbell_d;
   logic [DROP_CTR_W-1:0]      dropCount_q, dropCount_d;
   logic                       dropInc;
   logic                       wrEn;
   logic [7:0]                 wrByte;
   logic                       frameStart;

   // A start needs a low sample first, so a frame already running at reset is never picked up mid-way.
   assign frameStart = bus.rx_axi_valid_i & ~valid_q & armed_q;
   assign wrByte     = {bus.rx_axi_data_i, shift_q};

   always_comb begin
      state_d     = state_q;
      byteAddr_d  = byteAddr_q;
      maxAddr_d   = maxAddr_q;
      dibitCtr_d  = dibitCtr_q;
      shift_d     = shift_q;
      doorbell_d  = 1'b0;
      dropInc     = 1'b0;
      wrEn        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (frameStart) begin
               shift_d    = {4'b0000, bus.rx_axi_data_i};
               dibitCtr_d = 2'd1;
               byteAddr_d = '0;
               state_d    = ST_RX;
            end
         end

         ST_RX: begin
            if (bus.rx_axi_valid_i) begin
               if (dibitCtr_q == 2'd3) begin
                  if (byteAddr_q == FULL_ADDR) begin
                     dropInc = 1'b1;
                     state_d = ST_DROP;
                  end else begin
                     wrEn       = 1'b1;
                     byteAddr_d = byteAddr_q + 11'd1;
                     dibitCtr_d = 2'd0;
                  end
               end else begin
                  shift_d[{dibitCtr_q, 1'b0} +: 2] = bus.rx_axi_data_i;
                  dibitCtr_d = dibitCtr_q + 2'd1;
               end
            end else if ((dibitCtr_q == 2'd0) && (byteAddr_q != 11'd0)) begin
               maxAddr_d  = byteAddr_q - 11'd1;
               doorbell_d = 1'b1;
               state_d    = ST_HOLD;
            end else begin
               dropInc = 1'b1;
               state_d = ST_IDLE;
            end
         end

         ST_DROP: begin
            if (!bus.rx_axi_valid_i) begin
               state_d = ST_IDLE;
            end
         end

         ST_HOLD: begin
            if (frameStart) begin
               dropInc = 1'b1;
            end
            if (bus.release_i) begin
               byteAddr_d = '0;
               dibitCtr_d = 2'd0;
               state_d    = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      dropCount_d = dropCount_q;
      if (dropInc && (dropCount_q != {DROP_CTR_W{1'b1}})) begin
         dropCount_d = dropCount_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         byteAddr_q  <= '0;
         maxAddr_q   <= '0;
         dibitCtr_q  <= '0;
         shift_q     <= '0;
         valid_q     <= 1'b0;
         armed_q     <= 1'b0;
         doorbell_q  <= 1'b0;
         dropCount_q <= '0;
      end else begin
         state_q     <= state_d;
         byteAddr_q  <= byteAddr_d;
         maxAddr_q   <= maxAddr_d;
         dibitCtr_q  <= dibitCtr_d;
         shift_q     <= shift_d;
         valid_q     <= bus.rx_axi_valid_i;
         armed_q     <= armed_q | ~bus.rx_axi_valid_i;
         doorbell_q  <= doorbell_d;
         dropCount_q <= dropCount_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pktbuf_q <= '0;
      end else if (wrEn) begin
         pktbuf_q[byteAddr_q] <= wrByte;
      end
   end

   assign bus.pktbuf_o         = pktbuf_q;
   assign bus.pktbuf_maxaddr_o = maxAddr_q;
   assign bus.doorbell_o       = doorbell_q;
   assign bus.pkt_held_o       = (state_q == ST_HOLD);
   assign bus.drop_count_o     = dropCount_q;

endmodule

// File: tb/tb_mac_rx_ifc.sv
// Bench for mac_rx_ifc: a table of frames with explicit outcomes, directed release/reset sequences,
// and random frames scored by a frame-level model of hold/drop behaviour.
module tb_mac_rx_ifc;

   localparam int MAX_BYTES  = 1518;
   localparam int DROP_CTR_W = 8;
   localparam int DROP_SAT   = (1 << DROP_CTR_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mac_rx_ifc_if #(.MAX_BYTES(MAX_BYTES), .DROP_CTR_W(DROP_CTR_W)) bus ();

   mac_rx_ifc #(.MAX_BYTES(MAX_BYTES), .DROP_CTR_W(DROP_CTR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         nBytes;
      int         extraDib;
      logic [7:0] b0, b1, b2, b3;
      bit         relBefore;
      bit         expDoorbell;
      bit         expHeld;
      int         expMax;
      int         expDrop;
   } vec_t;

   vec_t       vecs[9];
   int         nChecks = 0;
   int         nErrors = 0;
   int         dbSeen  = 0;
   int         mDb     = 0;
   int         mDrop   = 0;
   int         mMax    = 0;
   bit         mHeld   = 1'b0;
   logic [7:0] frameBytes[0:1599];
   logic [7:0] mBuf[0:MAX_BYTES-1];

   // Doorbell pulses are counted on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      if (bus.doorbell_o === 1'b1) dbSeen++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
      end
   endtask

   task automatic checkBuf(input string name, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         if (bus.pktbuf_o[i] !== mBuf[i]) bad++;
      end
      checkOutput({name, " bad bytes"}, bad, 0);
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, " held"}, {31'd0, bus.pkt_held_o}, {31'd0, mHeld});
      checkOutput({tag, " drops"}, 32'(bus.drop_count_o), mDrop);
      checkOutput({tag, " doorbells"}, dbSeen, mDb);
      if (mHeld) begin
         checkOutput({tag, " maxaddr"}, 32'(bus.pktbuf_maxaddr_o), mMax);
         checkBuf(tag, mMax + 1);
      end
   endtask

   task automatic satInc();
      mDrop = (mDrop == DROP_SAT) ? DROP_SAT : mDrop + 1;
   endtask

   // Frame-level outcome: captured only when idle, whole bytes, non-empty and within the buffer.
   task automatic modelFrame(input int n, input int extra);
      if (mHeld || (extra != 0) || (n == 0) || (n > MAX_BYTES)) begin
         satInc();
      end else begin
         mHeld = 1'b1;
         mMax  = n - 1;
         for (int j = 0; j < n; j++) mBuf[j] = frameBytes[j];
         mDb++;
      end
   endtask

   task automatic resetModelAndCheck();
      mHeld = 1'b0;
      mDrop = 0;
      mMax  = 0;
      for (int j = 0; j < MAX_BYTES; j++) mBuf[j] = 8'h00;
      checkState("async rst");
      checkOutput("async rst doorbell", {31'd0, bus.doorbell_o}, 0);
      checkOutput("async rst maxaddr", 32'(bus.pktbuf_maxaddr_o), 0);
      checkBuf("async rst buffer", MAX_BYTES);
   endtask

   task automatic applyStimulus(input int nDib, input int relAt, input int rstAt);
      for (int k = 0; k < nDib; k++) begin
         bus.rx_axi_valid_i = 1'b1;
         bus.rx_axi_data_i  = frameBytes[k/4][(k%4)*2 +: 2];
         bus.release_i      = (k == relAt);
         if (k == rstAt) begin
            #2 rst = 1'b1;
            #1 resetModelAndCheck();
            #1 rst = 1'b0;
         end
         tick();
      end
      bus.rx_axi_valid_i = 1'b0;
      bus.release_i      = 1'b0;
   endtask

   task automatic fillRandom(input int n);
      for (int j = 0; j < n; j++) frameBytes[j] = 8'($urandom);
   endtask

   task automatic sendFrame(input string tag, input int n, input int extra);
      modelFrame(n, extra);
      applyStimulus(4 * n + extra, -1, -1);
      tick();
      tick();
      checkState(tag);
   endtask

   initial begin
      bus.rx_axi_valid_i = 1'b0;
      bus.rx_axi_data_i  = 2'b00;
      bus.release_i      = 1'b0;
      for (int j = 0; j < MAX_BYTES; j++) mBuf[j] = 8'h00;

      vecs[0] = '{4,    0, 8'hA5, 8'h3C, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b1, 3,    0};
      vecs[1] = '{4,    0, 8'h5A, 8'hC3, 8'h10, 8'hEE, 1'b0, 1'b0, 1'b1, 3,    1};
      vecs[2] = '{2,    0, 8'h11, 8'h22, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1,    1};
      vecs[3] = '{3,    2, 8'h77, 8'h88, 8'h99, 8'h00, 1'b1, 1'b0, 1'b0, 0,    2};
      vecs[4] = '{0,    2, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0,    3};
      vecs[5] = '{5,    0, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b1, 1'b1, 4,    3};
      vecs[6] = '{1518, 0, 8'h00, 8'h01, 8'h02, 8'h03, 1'b1, 1'b1, 1'b1, 1517, 3};
      vecs[7] = '{1519, 0, 8'h00, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0, 1'b0, 0,    4};
      vecs[8] = '{64,   0, 8'h00, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1'b1, 63,   4};

      repeat (3) tick();
      checkState("reset");
      checkOutput("reset doorbell", {31'd0, bus.doorbell_o}, 0);
      checkOutput("reset maxaddr", 32'(bus.pktbuf_maxaddr_o), 0);
      checkBuf("reset buffer", MAX_BYTES);
      rst = 1'b0;
      repeat (3) tick();

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].relBefore) begin
            bus.release_i = 1'b1;
            tick();
            bus.release_i = 1'b0;
         end
         repeat (2) tick();
         for (int j = 0; j < vecs[i].nBytes; j++) begin
            case (j)
               0:       frameBytes[j] = vecs[i].b0;
               1:       frameBytes[j] = vecs[i].b1;
               2:       frameBytes[j] = vecs[i].b2;
               3:       frameBytes[j] = vecs[i].b3;
               default: frameBytes[j] = 8'(j);
            endcase
         end
         applyStimulus(4 * vecs[i].nBytes + vecs[i].extraDib, -1, -1);
         tick();
         checkOutput($sformatf("vec%0d doorbell edge", i), {31'd0, bus.doorbell_o}, {31'd0, vecs[i].expDoorbell});
         checkOutput($sformatf("vec%0d held edge", i), {31'd0, bus.pkt_held_o}, {31'd0, vecs[i].expHeld});
         tick();
         checkOutput($sformatf("vec%0d doorbell width", i), {31'd0, bus.doorbell_o}, 0);
         mHeld = vecs[i].expHeld;
         mDrop = vecs[i].expDrop;
         if (vecs[i].expDoorbell) begin
            mMax = vecs[i].expMax;
            for (int j = 0; j < vecs[i].nBytes; j++) mBuf[j] = frameBytes[j];
            mDb++;
         end
         checkState($sformatf("vec%0d", i));
         if (i == 6) checkOutput("vec6 last byte", 32'(bus.pktbuf_o[1517]), 32'h0000_00ED);
      end

      // Release arriving mid-frame: the frame was counted at its start and its tail is ignored.
      fillRandom(8);
      applyStimulus(32, 12, -1);
      satInc();
      mHeld = 1'b0;
      repeat (2) tick();
      checkState("release mid");
      fillRandom(4);
      sendFrame("after release mid", 4, 0);

      fillRandom(4);
      applyStimulus(16, 0, -1);
      satInc();
      mHeld = 1'b0;
      repeat (2) tick();
      checkState("release at start");
      fillRandom(3);
      sendFrame("after release start", 3, 0);

      fillRandom(8);
      applyStimulus(32, -1, 10);
      repeat (2) tick();
      checkState("reset tail");
      fillRandom(2);
      sendFrame("after reset", 2, 0);

      for (int r = 0; r < 40; r++) begin
         int n;
         int extra;
         n     = $urandom_range(0, 12);
         extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         if (n == 0) extra = $urandom_range(1, 3);
         fillRandom(n);
         sendFrame($sformatf("rand%0d", r), n, extra);
         if ($urandom_range(0, 1) == 1) begin
            bus.release_i = 1'b1;
            tick();
            bus.release_i = 1'b0;
            mHeld = 1'b0;
         end
         repeat ($urandom_range(0, 2)) tick();
      end

      if (!mHeld) begin
         fillRandom(1);
         sendFrame("sat setup", 1, 0);
      end
      for (int r = 0; r < 300; r++) begin
         fillRandom(1);
         modelFrame(1, 0);
         applyStimulus(4, -1, -1);
         repeat (2) tick();
      end
      checkState("saturate");
      checkOutput("saturate value", 32'(bus.drop_count_o), DROP_SAT);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule

// File: doc/mac_rx_ifc.md
Name: mac_rx_ifc

Overview:
Receive-side counterpart of the MAC transmit interface. It accepts a stream of 2-bit dibits from the PHY-side receive path and assembles them LSB-first into bytes in a flat packet buffer. When a frame ends it raises a one-cycle doorbell and holds the frame until the consumer releases it. It sits between the RMII receive deserializer and the packet consumer (CRC check / dispatch logic).

Parameters:
MAX_BYTES, 1518, buffer depth in bytes (largest accepted frame)
DROP_CTR_W, 8, width of saturating dropped-frame counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx_axi_valid  input  1  dibit valid; high for the whole frame, low between frames; no backpressure
rx_axi_data  input  2  dibit; first dibit of a byte is bits [1:0], last is [7:6]
pktbuf  output  [MAX_BYTES-1:0][7:0]  received frame, byte 0 first
pktbuf_maxaddr  output  11  index of the last valid byte in pktbuf
doorbell  output  1  one-cycle pulse: frame complete and held
pkt_held  output  1  level: pktbuf/pktbuf_maxaddr are valid and frozen
release  input  1  consumer done with frame (sampled only in ST_HOLD)
drop_count  output  DROP_CTR_W  saturating count of discarded frames

Behaviour:
- Reset (async, immediate): state=ST_IDLE; pktbuf all 0; pktbuf_maxaddr=0; doorbell=0; pkt_held=0; drop_count=0; internal byte_addr, dibit_ctr, shift register, valid_q all 0.
- valid_q is the registered rx_axi_valid. Frame start = rx_axi_valid & ~valid_q.
- ST_IDLE: on frame start, capture that cycle's dibit as dibit 0 of byte 0, dibit_ctr->1, go to ST_RX. If valid is high without a start (mid-frame after reset or release), ignore it and stay.
- ST_RX, valid high: shift the dibit into position dibit_ctr*2. When dibit_ctr==3, write the completed byte to pktbuf[byte_addr] on that edge, byte_addr++, dibit_ctr->0. Otherwise dibit_ctr++.
- ST_RX overflow: a 4th dibit arriving with byte_addr==MAX_BYTES (a byte MAX_BYTES+1 would complete) -> go to ST_DROP, drop_count++. The buffer is not written.
- ST_RX, valid low (frame end), evaluated on the first low cycle:
  - dibit_ctr==0 and byte_addr>=1: next edge goes to ST_HOLD with pktbuf_maxaddr=byte_addr-1, doorbell=1 for exactly one cycle, pkt_held=1.
  - dibit_ctr!=0 (misaligned tail, including runts of 1-3 dibits): discard the frame, drop_count++, go to ST_IDLE.
  - Latency: doorbell rises one cycle after the first valid-low cycle.
- ST_DROP: ignore data; when valid is low, go to ST_IDLE.
- ST_HOLD: pktbuf and pktbuf_maxaddr are frozen. Each frame start seen in this state increments drop_count. If release=1: pkt_held->0, byte_addr->0, dibit_ctr->0, go to ST_IDLE. A frame already in progress at release is not captured, by the IDLE mid-frame rule.
- Simultaneous release and frame start in ST_HOLD: the frame is counted as dropped; release still takes effect.
- release outside ST_HOLD has no effect.
- drop_count saturates at all-ones and does not wrap.
- Bytes beyond pktbuf_maxaddr keep stale contents; the consumer must ignore them.
- Reset asserted mid-frame: clears everything. The remainder of that frame is ignored (valid still high, no start); the next frame is received normally.

Test Plan:
- Frame 0xA5,0x3C,0x01,0xFF sent as 16 dibits LSB-first (first dibits 01,01,10,10) -> pktbuf[0..3]=A5,3C,01,FF; pktbuf_maxaddr=3; doorbell high one cycle, one cycle after valid falls; pkt_held=1.
- Second 4-byte frame sent while held -> drop_count=1, pktbuf unchanged. Pulse release, send 0x11,0x22 -> pktbuf[0..1]=11,22; maxaddr=1; new doorbell.
- 14-dibit frame (3.5 bytes) and a 2-dibit runt -> no doorbell, pkt_held=0, drop_count+=2, state back to IDLE; next valid frame is accepted.
- 1518-byte frame with incrementing data -> maxaddr=1517, pktbuf[1517]=0xED. 1519-byte frame -> no doorbell, drop_count+1, and a following 64-byte frame is accepted.
- Release asserted while valid is high mid-frame -> that frame is not captured (counted once at its start); the next frame is received with correct data.
- Async rst pulse mid-frame (between clock edges) -> outputs clear immediately; frame tail ignored; next frame received. Send 300 frames during a hold -> drop_count saturates at 255.
